// File: rtl/spu_gbuf_if.sv
// Bus bundle between the SPU/host side and the global-buffer responder.
// master drives SPU and host requests; slave (the responder) returns data and status.
interface spu_gbuf_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  spu_start;
    logic                  spu_end;
    logic                  gbuf_cen;
    logic                  gbuf_wen;
    logic [ADDR_WIDTH-1:0] gbuf_raddr;
    logic [ADDR_WIDTH-1:0] gbuf_waddr;
    logic [DATA_WIDTH-1:0] gbuf_din;
    logic [DATA_WIDTH-1:0] gbuf_dout;
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_ready;
    logic                  host_rvalid;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic                  spu_owner;
    logic [15:0]           rd_cnt;
    logic [15:0]           wr_cnt;

    modport master (
        output spu_start, spu_end,
        output gbuf_cen, gbuf_wen, gbuf_raddr, gbuf_waddr, gbuf_din,
        input  gbuf_dout,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ready, host_rvalid, host_rdata,
        input  spu_owner, rd_cnt, wr_cnt
    );

    modport slave (
        input  spu_start, spu_end,
        input  gbuf_cen, gbuf_wen, gbuf_raddr, gbuf_waddr, gbuf_din,
        output gbuf_dout,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ready, host_rvalid, host_rdata,
        output spu_owner, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/spu_gbuf_responder.sv
// Global-buffer responder: 2**ADDR_WIDTH x DATA_WIDTH array shared by SPU and host.
// Ports: core_clk, rst_n (async, active-low), bus (spu_gbuf_if.slave).
// SPU side: active-low cen/wen, split raddr/waddr, 1-cycle registered dout,
//   saturating rd_cnt/wr_cnt cleared on spu_start.
// Host side: req/ready load/unload port, granted only while the SPU is idle.
// Option: define GBUF_RD_BYPASS_EN to forward gbuf_din to gbuf_dout on a
//   same-address SPU read/write; otherwise the old word is returned.
module spu_gbuf_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input logic         core_clk,
    input logic         rst_n,
    spu_gbuf_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_HOST  = 2'd0;
    localparam logic [1:0] S_SPU   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_host_ready;
    logic                  r_host_rvalid;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic [DATA_WIDTH-1:0] r_gbuf_dout;
    logic [15:0]           r_rd_cnt;
    logic [15:0]           r_wr_cnt;

    logic                  w_owner;
    logic                  w_spu_rd;
    logic                  w_spu_wr;
    logic                  w_host_acc;
    logic                  w_host_wr;
    logic                  w_host_rd;
    logic                  w_launch;
    logic [DATA_WIDTH-1:0] w_spu_rdata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HOST:  if (bus.spu_start) w_state_nxt = S_SPU;
            S_SPU:   if (bus.spu_end)   w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_HOST;
            default: w_state_nxt = S_HOST;
        endcase
    end

    assign w_owner  = (r_state != S_HOST);
    assign w_launch = (r_state == S_HOST) && bus.spu_start;
    assign w_spu_rd = w_owner && !bus.gbuf_cen;
    assign w_spu_wr = w_spu_rd && !bus.gbuf_wen;

    // ready can only be high while in HOST, so host and SPU never touch
    // the array in the same cycle
    assign w_host_acc = bus.host_req && r_host_ready;
    assign w_host_wr  = w_host_acc && bus.host_we;
    assign w_host_rd  = w_host_acc && !bus.host_we;

`ifdef GBUF_RD_BYPASS_EN
    assign w_spu_rdata = (w_spu_wr && (bus.gbuf_waddr == bus.gbuf_raddr))
                       ? bus.gbuf_din : r_mem[bus.gbuf_raddr];
`else
    assign w_spu_rdata = r_mem[bus.gbuf_raddr];
`endif

    // array has no reset; contents survive rst_n
    always_ff @(posedge core_clk) begin
        if (w_spu_wr)
            r_mem[bus.gbuf_waddr] <= bus.gbuf_din;
        else if (w_host_wr)
            r_mem[bus.host_addr] <= bus.host_wdata;
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_HOST;
            r_host_ready  <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
            r_gbuf_dout   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // staying in HOST is required so ready drops on the launch edge
            // and rises only in the second HOST cycle after DRAIN
            r_host_ready  <= (r_state == S_HOST) && (w_state_nxt == S_HOST);
            r_host_rvalid <= w_host_rd;
            if (w_host_rd)
                r_host_rdata <= r_mem[bus.host_addr];
            if (w_spu_rd)
                r_gbuf_dout <= w_spu_rdata;
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_launch) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_spu_rd && (r_rd_cnt != 16'hFFFF))
                r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_spu_wr && (r_wr_cnt != 16'hFFFF))
                r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    assign bus.gbuf_dout   = r_gbuf_dout;
    assign bus.host_ready  = r_host_ready;
    assign bus.host_rvalid = r_host_rvalid;
    assign bus.host_rdata  = r_host_rdata;
    assign bus.spu_owner   = w_owner;
    assign bus.rd_cnt      = r_rd_cnt;
    assign bus.wr_cnt      = r_wr_cnt;
endmodule
